// File: rtl/mem_lsu_queue_pkg.sv
// rtl/mem_lsu_queue_pkg.sv - shared types and constants for the in-order load/store queue
//
// Contents:
//   LD_* load type encodings, DATA_W/ADDR_W defaults, per-entry control struct.
//   Meta and data are kept in separate arrays in the top because their widths
//   are parameters of the queue.

package mem_lsu_queue_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int ADDR_W_DEF = 32;
   localparam int META_W_DEF = 64;

   localparam logic [2:0] LD_W  = 3'b000;
   localparam logic [2:0] LD_HU = 3'b010;
   localparam logic [2:0] LD_H  = 3'b011;
   localparam logic [2:0] LD_BU = 3'b100;
   localparam logic [2:0] LD_B  = 3'b101;

   typedef struct packed {
      logic [1:0] addr_lo;
      logic [2:0] ld_type;
      logic       req;
      logic       done;
      logic       ale;
   } entry_ctl_t;

endpackage

// File: rtl/mem_load_ext.sv
// rtl/mem_load_ext.sv - combinational load byte/half/word extension
//
// Ports:
//   ld_type  in  3       load type (LD_* encodings)
//   addr_lo  in  2       access address bits [1:0]
//   raw      in  DATA_W  raw SRAM read data
//   ext      out DATA_W  extended result; unknown ld_type gives 0

module mem_load_ext
   import mem_lsu_queue_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic [2:0]        ld_type,
   input  logic [1:0]        addr_lo,
   input  logic [DATA_W-1:0] raw,
   output logic [DATA_W-1:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = raw[{addr_lo, 3'b000} +: 8];
      half_sel = raw[{addr_lo[1], 4'b0000} +: 16];
      case (ld_type)
         LD_W:    ext = raw;
         LD_HU:   ext = {{(DATA_W-16){1'b0}}, half_sel};
         LD_H:    ext = {{(DATA_W-16){half_sel[15]}}, half_sel};
         LD_BU:   ext = {{(DATA_W-8){1'b0}}, byte_sel};
         LD_B:    ext = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
         default: ext = '0;
      endcase
   end

endmodule

// File: rtl/mem_lsu_queue.sv
// rtl/mem_lsu_queue.sv - in-order MEM stage queue tracking DEPTH outstanding data-SRAM accesses
//
// Optional feature macro: MEM_ALIGN_CHECK_EN (misaligned word/half -> ALE entry).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   ex_valid_i              EX offers an instruction
//   mem_allowin_o           queue can accept this cycle
//   ex_req_i                instruction issued a data-SRAM request
//   ex_ld_type_i            load type (LD_* encodings)
//   ex_addr_i               access address
//   ex_result_i             ALU result for non-load / store
//   ex_meta_i               passthrough bundle
//   data_sram_data_ok_i     one response beat
//   data_sram_rdata_i       response data
//   excep_flush_i           pipeline flush
//   wb_allowin_i            WB accepts
//   mem_to_wb_valid_o       head entry complete
//   wb_result_o             extended load data or ex_result
//   wb_meta_o               head entry meta
//   wb_excep_o              head entry raised ALE
//   inflight_o              live entries plus responses owed to flushed accesses
//   dr_stall_o              some live entry still waits for its response

module mem_lsu_queue
   import mem_lsu_queue_pkg::*;
#(
   parameter int DEPTH  = 2,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int META_W = META_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       ex_valid_i,
   output logic                       mem_allowin_o,
   input  logic                       ex_req_i,
   input  logic [2:0]                 ex_ld_type_i,
   input  logic [ADDR_W-1:0]          ex_addr_i,
   input  logic [DATA_W-1:0]          ex_result_i,
   input  logic [META_W-1:0]          ex_meta_i,
   input  logic                       data_sram_data_ok_i,
   input  logic [DATA_W-1:0]          data_sram_rdata_i,
   input  logic                       excep_flush_i,
   input  logic                       wb_allowin_i,
   output logic                       mem_to_wb_valid_o,
   output logic [DATA_W-1:0]          wb_result_o,
   output logic [META_W-1:0]          wb_meta_o,
   output logic                       wb_excep_o,
   output logic [$clog2(DEPTH+1)-1:0] inflight_o,
   output logic                       dr_stall_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0]  valid_q;
   entry_ctl_t        ctl_q  [DEPTH];
   logic [META_W-1:0] meta_q [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, rd_ptr_q, rsp_ptr, scan_idx;
   logic [CW-1:0] count_q, drop_cnt_q, drop_cnt_nxt, pending_cnt, flush_sum, occ;
   logic          rsp_found, rsp_wr, enq, pop, ale_live;
   entry_ctl_t    enq_ctl;
   logic          unused_addr_hi;

   assign unused_addr_hi = ^ex_addr_i[ADDR_W-1:2];

   // Live entries are contiguous from the head, so scanning from rd_ptr
   // finds the oldest entry still owed a response (responses return in order).
   always_comb begin
      rsp_found   = 1'b0;
      rsp_ptr     = rd_ptr_q;
      pending_cnt = '0;
      scan_idx    = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         scan_idx = rd_ptr_q + PW'(i);
         if (valid_q[scan_idx] && ctl_q[scan_idx].req && !ctl_q[scan_idx].done) begin
            pending_cnt = pending_cnt + CW'(1);
            if (!rsp_found) begin
               rsp_found = 1'b1;
               rsp_ptr   = scan_idx;
            end
         end
      end
   end

   always_comb begin
      ale_live = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      for (int i = 0; i < DEPTH; i++) begin
         if (valid_q[i] && ctl_q[i].ale) ale_live = 1'b1;
      end
`endif
   end

   always_comb begin
      enq_ctl.addr_lo = ex_addr_i[1:0];
      enq_ctl.ld_type = ex_ld_type_i;
      enq_ctl.req     = ex_req_i;
      enq_ctl.done    = ~ex_req_i;
      enq_ctl.ale     = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
      if ((ex_ld_type_i == LD_W && ex_addr_i[1:0] != 2'b00) ||
          ((ex_ld_type_i == LD_HU || ex_ld_type_i == LD_H) && ex_addr_i[0])) begin
         enq_ctl.ale  = 1'b1;
         enq_ctl.req  = 1'b0;
         enq_ctl.done = 1'b1;
      end
`endif
   end

   // Room is judged on registered state only: a pop this cycle frees a slot
   // next cycle, keeping wb_allowin_i off the mem_allowin_o path.
   assign occ               = count_q + drop_cnt_q;
   assign inflight_o        = occ;
   assign mem_allowin_o     = (occ < CW'(DEPTH)) & ~excep_flush_i & ~ale_live;
   assign enq               = ex_valid_i & mem_allowin_o;
   assign mem_to_wb_valid_o = valid_q[rd_ptr_q] & ctl_q[rd_ptr_q].done & ~excep_flush_i;
   assign pop               = mem_to_wb_valid_o & wb_allowin_i;
   assign dr_stall_o        = (pending_cnt != '0);

   // A response in the flush cycle always goes to the drop budget, which
   // already includes every pending entry being invalidated now.
   always_comb begin
      rsp_wr       = 1'b0;
      flush_sum    = drop_cnt_q + pending_cnt;
      drop_cnt_nxt = drop_cnt_q;
      if (excep_flush_i) begin
         drop_cnt_nxt = flush_sum;
         if (data_sram_data_ok_i && flush_sum != '0) drop_cnt_nxt = flush_sum - CW'(1);
      end else if (data_sram_data_ok_i) begin
         if (drop_cnt_q != '0) drop_cnt_nxt = drop_cnt_q - CW'(1);
         else                  rsp_wr       = rsp_found;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
         for (int i = 0; i < DEPTH; i++) ctl_q[i] <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_nxt;
         if (excep_flush_i) begin
            valid_q  <= '0;
            count_q  <= '0;
            rd_ptr_q <= wr_ptr_q;
         end else begin
            if (rsp_wr) ctl_q[rsp_ptr].done <= 1'b1;
            if (pop) begin
               valid_q[rd_ptr_q] <= 1'b0;
               rd_ptr_q          <= rd_ptr_q + PW'(1);
            end
            if (enq) begin
               valid_q[wr_ptr_q] <= 1'b1;
               ctl_q[wr_ptr_q]   <= enq_ctl;
               wr_ptr_q          <= wr_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         meta_q[wr_ptr_q] <= ex_meta_i;
         data_q[wr_ptr_q] <= ex_result_i;
      end
      if (rsp_wr) data_q[rsp_ptr] <= data_sram_rdata_i;
   end

   mem_load_ext #(.DATA_W(DATA_W)) u_load_ext (
      .ld_type (ctl_q[rd_ptr_q].ld_type),
      .addr_lo (ctl_q[rd_ptr_q].addr_lo),
      .raw     (data_q[rd_ptr_q]),
      .ext     (wb_result_o)
   );

   assign wb_meta_o = meta_q[rd_ptr_q];

`ifdef MEM_ALIGN_CHECK_EN
   assign wb_excep_o = valid_q[rd_ptr_q] & ctl_q[rd_ptr_q].ale;
`else
   assign wb_excep_o = 1'b0;
`endif

endmodule

// File: tb/tb_mem_lsu_queue.sv
// tb/tb_mem_lsu_queue.sv - scoreboard bench for mem_lsu_queue (DEPTH=2)

module tb_mem_lsu_queue;
   import mem_lsu_queue_pkg::*;

   typedef struct packed {
      logic [31:0] res;
      logic [63:0] meta;
      logic        exc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        ex_valid_i = 1'b0;
   logic        mem_allowin_o;
   logic        ex_req_i = 1'b0;
   logic [2:0]  ex_ld_type_i = 3'b000;
   logic [31:0] ex_addr_i = '0;
   logic [31:0] ex_result_i = '0;
   logic [63:0] ex_meta_i = '0;
   logic        data_sram_data_ok_i = 1'b0;
   logic [31:0] data_sram_rdata_i = '0;
   logic        excep_flush_i = 1'b0;
   logic        wb_allowin_i = 1'b1;
   logic        mem_to_wb_valid_o;
   logic [31:0] wb_result_o;
   logic [63:0] wb_meta_o;
   logic        wb_excep_o;
   logic [1:0]  inflight_o;
   logic        dr_stall_o;

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t sb[$];

   mem_lsu_queue #(.DEPTH(2), .DATA_W(32), .ADDR_W(32), .META_W(64)) dut (
      .clk                 (clk),
      .rst_n               (rst_n),
      .ex_valid_i          (ex_valid_i),
      .mem_allowin_o       (mem_allowin_o),
      .ex_req_i            (ex_req_i),
      .ex_ld_type_i        (ex_ld_type_i),
      .ex_addr_i           (ex_addr_i),
      .ex_result_i         (ex_result_i),
      .ex_meta_i           (ex_meta_i),
      .data_sram_data_ok_i (data_sram_data_ok_i),
      .data_sram_rdata_i   (data_sram_rdata_i),
      .excep_flush_i       (excep_flush_i),
      .wb_allowin_i        (wb_allowin_i),
      .mem_to_wb_valid_o   (mem_to_wb_valid_o),
      .wb_result_o         (wb_result_o),
      .wb_meta_o           (wb_meta_o),
      .wb_excep_o          (wb_excep_o),
      .inflight_o          (inflight_o),
      .dr_stall_o          (dr_stall_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Offer one instruction; it must be accepted. Expected WB output is queued
   // only for instructions that will retire.
   task automatic issue(input logic [2:0] lt, input logic [31:0] addr, input logic req,
                        input logic [31:0] res, input logic [63:0] meta,
                        input logic retire, input logic [31:0] exp_res);
      ex_valid_i   = 1'b1;
      ex_ld_type_i = lt;
      ex_addr_i    = addr;
      ex_req_i     = req;
      ex_result_i  = res;
      ex_meta_i    = meta;
      if (retire) sb.push_back('{res: exp_res, meta: meta, exc: 1'b0});
      @(negedge clk);
      chk("issue_allowin", {63'd0, mem_allowin_o}, 64'd1);
      step();
      ex_valid_i = 1'b0;
      ex_req_i   = 1'b0;
   endtask

   task automatic rsp(input logic [31:0] data);
      data_sram_data_ok_i = 1'b1;
      data_sram_rdata_i   = data;
      step();
      data_sram_data_ok_i = 1'b0;
   endtask

   // Monitor: compares every WB handshake against the scoreboard and checks
   // that each response beat has an owner.
   always @(negedge clk) begin
      if (rst_n && data_sram_data_ok_i)
         chk("rsp_has_owner", {63'd0, (dut.drop_cnt_q != '0) || dut.rsp_found}, 64'd1);
      if (rst_n && mem_to_wb_valid_o && wb_allowin_i) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wb_unexpected: got %h want no output", wb_result_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_result", {32'd0, wb_result_o}, {32'd0, e.res});
            chk("wb_meta", wb_meta_o, e.meta);
            chk("wb_excep", {63'd0, wb_excep_o}, {63'd0, e.exc});
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("rst_valid", {63'd0, mem_to_wb_valid_o}, 64'd0);
      chk("rst_stall", {63'd0, dr_stall_o}, 64'd0);
      chk("rst_inflight", {62'd0, inflight_o}, 64'd0);
      chk("rst_allowin", {63'd0, mem_allowin_o}, 64'd1);
      step();

      // single ld.b at ...3: byte 0x80 sign-extended
      issue(LD_B, 32'h0000_1003, 1'b1, 32'h0, 64'hA1, 1'b1, 32'hFFFF_FF80);
      @(negedge clk);
      chk("ldb_stall", {63'd0, dr_stall_o}, 64'd1);
      @(posedge clk); #1;
      rsp(32'h80FF_1234);
      @(negedge clk);
      chk("ldb_latency", {63'd0, mem_to_wb_valid_o}, 64'd1);
      step();
      step();

      // back-to-back ld.w fills DEPTH=2, third offer refused, in-order return
      issue(LD_W, 32'h0000_0100, 1'b1, 32'h0, 64'hB1, 1'b1, 32'h11);
      issue(LD_W, 32'h0000_0104, 1'b1, 32'h0, 64'hB2, 1'b1, 32'h22);
      ex_valid_i = 1'b1;
      @(negedge clk);
      chk("full_allowin", {63'd0, mem_allowin_o}, 64'd0);
      chk("full_inflight", {62'd0, inflight_o}, 64'd2);
      step();
      ex_valid_i = 1'b0;
      rsp(32'h11);
      rsp(32'h22);
      step();
      step();

      // WB backpressure with a completed non-load at the head
      wb_allowin_i = 1'b0;
      issue(LD_W, 32'h0, 1'b0, 32'hCAFE_0001, 64'hC1, 1'b1, 32'hCAFE_0001);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid", {63'd0, mem_to_wb_valid_o}, 64'd1);
         chk("bp_result", {32'd0, wb_result_o}, 64'hCAFE_0001);
         step();
      end
      wb_allowin_i = 1'b1;
      step();
      @(negedge clk);
      chk("bp_popped", {63'd0, mem_to_wb_valid_o}, 64'd0);
      step();

      // streaming: pop and enqueue in the same cycle, pointer wrap, extension variants
      issue(LD_W, 32'h0, 1'b0, 32'h1234_5678, 64'hD1, 1'b1, 32'h1234_5678);
      issue(3'b111, 32'h0, 1'b0, 32'h1234_5678, 64'hD2, 1'b1, 32'h0);
      issue(LD_W, 32'h0, 1'b0, 32'h0BAD_F00D, 64'hD3, 1'b1, 32'h0BAD_F00D);
      issue(LD_H, 32'h0000_0502, 1'b1, 32'h0, 64'hD4, 1'b1, 32'hFFFF_8001);
      rsp(32'h8001_0000);
      issue(LD_BU, 32'h0000_0501, 1'b1, 32'h0, 64'hD5, 1'b1, 32'h0000_00A5);
      rsp(32'h0000_A500);
      step();
      step();

      // flush with two pending loads: their responses are swallowed
      issue(LD_W, 32'h0000_0300, 1'b1, 32'h0, 64'hE1, 1'b0, 32'h0);
      issue(LD_W, 32'h0000_0304, 1'b1, 32'h0, 64'hE2, 1'b0, 32'h0);
      excep_flush_i = 1'b1;
      @(negedge clk);
      chk("flush_allowin", {63'd0, mem_allowin_o}, 64'd0);
      chk("flush_valid", {63'd0, mem_to_wb_valid_o}, 64'd0);
      step();
      excep_flush_i = 1'b0;
      @(negedge clk);
      chk("drop_inflight", {62'd0, inflight_o}, 64'd2);
      chk("drop_allowin", {63'd0, mem_allowin_o}, 64'd0);
      chk("drop_stall", {63'd0, dr_stall_o}, 64'd0);
      step();
      rsp(32'hDEAD_0000);
      @(negedge clk);
      chk("drop1_inflight", {62'd0, inflight_o}, 64'd1);
      step();
      rsp(32'hDEAD_0001);
      @(negedge clk);
      chk("drop2_inflight", {62'd0, inflight_o}, 64'd0);
      step();
      issue(LD_HU, 32'h0000_0200, 1'b1, 32'h0, 64'hE3, 1'b1, 32'h0000_BEEF);
      rsp(32'hAAAA_BEEF);
      step();
      step();

      // flush coincident with the only pending response
      issue(LD_W, 32'h0000_0400, 1'b1, 32'h0, 64'hF1, 1'b0, 32'h0);
      excep_flush_i       = 1'b1;
      data_sram_data_ok_i = 1'b1;
      data_sram_rdata_i   = 32'h55;
      step();
      excep_flush_i       = 1'b0;
      data_sram_data_ok_i = 1'b0;
      @(negedge clk);
      chk("coinc_inflight", {62'd0, inflight_o}, 64'd0);
      chk("coinc_allowin", {63'd0, mem_allowin_o}, 64'd1);
      step();

`ifdef MEM_ALIGN_CHECK_EN
      // misaligned ld.w becomes an ALE entry that blocks until flush
      wb_allowin_i = 1'b0;
      issue(LD_W, 32'h0000_0602, 1'b0, 32'h0000_0602, 64'h61, 1'b0, 32'h0);
      @(negedge clk);
      chk("ale_valid", {63'd0, mem_to_wb_valid_o}, 64'd1);
      chk("ale_excep", {63'd0, wb_excep_o}, 64'd1);
      for (int i = 0; i < 3; i++) begin
         chk("ale_allowin", {63'd0, mem_allowin_o}, 64'd0);
         step();
         @(negedge clk);
      end
      step();
      excep_flush_i = 1'b1;
      step();
      excep_flush_i = 1'b0;
      wb_allowin_i  = 1'b1;
      @(negedge clk);
      chk("ale_release", {63'd0, mem_allowin_o}, 64'd1);
      step();
`endif

      for (int i = 0; i < 50 && sb.size() != 0; i++) step();
      chk("sb_drained", 64'(sb.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
